irq_controller: RTL and testbench

- Receiving end of the device interrupt lines. Timer and peripheral `irq_pin` outputs feed this block, which hands a single prioritised request and vector to the CPU.
- Edge-detects up to NUM_IRQ lines into a pending register and applies a per-line mask.
- Runs a request/acknowledge/end-of-interrupt handshake with the CPU core.
- Drives `global_int_en` back to the devices, and exposes a small register port for mask, pending and control.

---
 rtl/irq_controller_if.sv | 24 ++
 rtl/irq_controller.sv | 145 ++++++++++++++
 tb/tb_irq_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// CPU-facing bus for irq_controller: the config register port plus the
// request/ack/EOI interrupt handshake.
interface irq_controller_if #(
  parameter int VEC_W = 3
);
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic [31:0]      cfg_rdata;
  logic             int_req;
  logic [VEC_W-1:0] int_vec;
  logic             int_ack;
  logic             int_eoi;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
    input  cfg_rdata, int_req, int_vec
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, int_ack, int_eoi,
    output cfg_rdata, int_req, int_vec
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller: edge-detects device lines into a pending register,
// masks them, and hands the lowest-index request to the CPU.
//
// state   | meaning
// IDLE    | no request outstanding; global_int_en follows ie
// REQ     | int_req high, int_vec tracks the best pending source
// SERVICE | CPU acknowledged; int_vec frozen until EOI
module irq_controller #(
  parameter int NUM_IRQ = 8,
  parameter int VEC_W   = 3
) (
  input  logic               clk,
  input  logic               clr,
  input  logic [NUM_IRQ-1:0] irq_in,
  output logic               global_int_en,
  irq_controller_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t             state_q, state_d;
  logic [NUM_IRQ-1:0] irq_prev_q, irq_prev_d;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               ie_q, ie_d;
  logic               in_service_q, in_service_d;
  logic               int_req_q, int_req_d;
  logic [VEC_W-1:0]   int_vec_q, int_vec_d;
  logic               gie_q, gie_d;

  logic [NUM_IRQ-1:0] rise, masked, w1c_clr, ack_clr;
  logic [VEC_W-1:0]   win_idx;
  logic               any_req;
  logic               wr_mask, wr_pend, wr_ctrl;
  logic [31:0]        rdata;
  logic               unused_wdata;

  assign unused_wdata = ^bus.cfg_wdata;

  always_comb begin
    rise    = irq_in & ~irq_prev_q;
    masked  = pending_q & mask_q;
    any_req = |masked;
    win_idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (masked[i]) win_idx = VEC_W'(i);
    end
    wr_mask = bus.cfg_we && (bus.cfg_addr == 2'd0);
    wr_pend = bus.cfg_we && (bus.cfg_addr == 2'd1);
    wr_ctrl = bus.cfg_we && (bus.cfg_addr == 2'd2);
    w1c_clr = wr_pend ? bus.cfg_wdata[NUM_IRQ-1:0] : '0;
  end

  always_comb begin
    state_d      = state_q;
    int_req_d    = int_req_q;
    int_vec_d    = int_vec_q;
    in_service_d = in_service_q;
    ack_clr      = '0;
    case (state_q)
      IDLE: begin
        if (ie_q && any_req) begin
          state_d   = REQ;
          int_req_d = 1'b1;
          int_vec_d = win_idx;
        end
      end
      REQ: begin
        if (!ie_q || !any_req) begin
          state_d   = IDLE;
          int_req_d = 1'b0;
        end else if (bus.int_ack) begin
          // clear the source the CPU actually saw, not a same-cycle newcomer
          state_d      = SERVICE;
          int_req_d    = 1'b0;
          in_service_d = 1'b1;
          for (int i = 0; i < NUM_IRQ; i++) begin
            if (int_vec_q == VEC_W'(i)) ack_clr[i] = 1'b1;
          end
        end else begin
          int_vec_d = win_idx;
        end
      end
      SERVICE: begin
        if (bus.int_eoi) begin
          state_d      = IDLE;
          in_service_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    irq_prev_d = irq_in;
    // set after clear: a new edge survives a coincident W1C or ack
    pending_d  = (pending_q & ~w1c_clr & ~ack_clr) | rise;
    mask_d     = wr_mask ? bus.cfg_wdata[NUM_IRQ-1:0] : mask_q;
    ie_d       = wr_ctrl ? bus.cfg_wdata[0] : ie_q;
    gie_d      = ie_q && (state_q == IDLE);
  end

  always_ff @(posedge clk) begin
    if (!clr) begin
      state_q      <= IDLE;
      irq_prev_q   <= '1;
      pending_q    <= '0;
      mask_q       <= '0;
      ie_q         <= 1'b0;
      in_service_q <= 1'b0;
      int_req_q    <= 1'b0;
      int_vec_q    <= '0;
      gie_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      irq_prev_q   <= irq_prev_d;
      pending_q    <= pending_d;
      mask_q       <= mask_d;
      ie_q         <= ie_d;
      in_service_q <= in_service_d;
      int_req_q    <= int_req_d;
      int_vec_q    <= int_vec_d;
      gie_q        <= gie_d;
    end
  end

  always_comb begin
    rdata = '0;
    case (bus.cfg_addr)
      2'd0: rdata[NUM_IRQ-1:0] = mask_q;
      2'd1: rdata[NUM_IRQ-1:0] = pending_q;
      2'd2: rdata[0]           = ie_q;
      default: begin
        rdata[0]       = in_service_q;
        rdata[8+:VEC_W] = int_vec_q;
      end
    endcase
  end

  assign bus.cfg_rdata  = rdata;
  assign bus.int_req    = int_req_q;
  assign bus.int_vec    = int_vec_q;
  assign global_int_en  = gie_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: register table plus handshake
// sequences, expectations queued on drive and popped on sample.
module tb_irq_controller;

  logic       clk = 1'b0;
  logic       clr;
  logic [7:0] irq_in;
  logic       global_int_en;

  irq_controller_if #(.VEC_W(3)) bus ();

  irq_controller #(.NUM_IRQ(8), .VEC_W(3)) dut (
    .clk           (clk),
    .clr           (clr),
    .irq_in        (irq_in),
    .global_int_en (global_int_en),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb_q[$];

  typedef struct {
    logic        we;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t tbl[7];

  task automatic push(input logic [31:0] v);
    sb_q.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] act);
    logic [31:0] e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL %s: got %h, no expectation queued", nm, act);
    end else begin
      e = sb_q.pop_front();
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = a;
    bus.cfg_wdata = d;
    cyc(1);
    bus.cfg_we    = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.cfg_addr = a;
    #1;
    d = bus.cfg_rdata;
  endtask

  task automatic exp_rd(input string nm, input logic [1:0] a, input logic [31:0] e);
    logic [31:0] d;
    push(e);
    rd(a, d);
    check(nm, d);
  endtask

  task automatic exp_req(input string nm, input logic r, input logic [2:0] v);
    push({31'b0, r});
    check({nm, "_req"}, {31'b0, bus.int_req});
    if (r) begin
      push({29'b0, v});
      check({nm, "_vec"}, {29'b0, bus.int_vec});
    end
  endtask

  task automatic exp_gie(input string nm, input logic g);
    push({31'b0, g});
    check(nm, {31'b0, global_int_en});
  endtask

  task automatic pulse_ack();
    bus.int_ack = 1'b1;
    cyc(1);
    bus.int_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    bus.int_eoi = 1'b1;
    cyc(1);
    bus.int_eoi = 1'b0;
  endtask

  initial begin
    tbl[0] = '{1'b1, 2'd0, 32'h0000_005A, 32'h0000_005A, "mask_rw"};
    tbl[1] = '{1'b1, 2'd0, 32'hFFFF_FFFF, 32'h0000_00FF, "mask_unused0"};
    tbl[2] = '{1'b1, 2'd2, 32'hFFFF_FFFE, 32'h0000_0000, "ctrl_bit0_only"};
    tbl[3] = '{1'b1, 2'd2, 32'h0000_0003, 32'h0000_0001, "ctrl_ie_set"};
    tbl[4] = '{1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, "status_ro"};
    tbl[5] = '{1'b1, 2'd1, 32'h0000_00FF, 32'h0000_0000, "pend_w1c_empty"};
    tbl[6] = '{1'b0, 2'd0, 32'h0000_0000, 32'h0000_00FF, "mask_hold"};

    clr = 1'b0; irq_in = 8'hFF;
    bus.cfg_we = 1'b0; bus.cfg_addr = 2'd0; bus.cfg_wdata = '0;
    bus.int_ack = 1'b0; bus.int_eoi = 1'b0;
    cyc(2);
    exp_req("reset", 1'b0, 3'd0);
    push(32'h0);
    check("reset_vec", {29'b0, bus.int_vec});
    exp_gie("reset_gie", 1'b0);
    exp_rd("reset_status", 2'd3, 32'h0);

    // lines high through reset must not trigger
    clr = 1'b1;
    wr(2'd0, 32'hFF);
    wr(2'd2, 32'h1);
    cyc(3);
    exp_req("idle_after_reset", 1'b0, 3'd0);
    exp_rd("idle_pending", 2'd1, 32'h0);
    exp_gie("idle_gie", 1'b1);
    irq_in = 8'h00;
    cyc(2);

    for (int i = 0; i < 7; i++) begin
      if (tbl[i].we) wr(tbl[i].addr, tbl[i].wdata);
      exp_rd(tbl[i].name, tbl[i].addr, tbl[i].exp);
    end

    // single tick on line 0
    wr(2'd0, 32'h01);
    irq_in = 8'h01;
    cyc(1);
    exp_req("tick_t1", 1'b0, 3'd0);
    cyc(1);
    exp_req("tick_t2", 1'b1, 3'd0);
    cyc(2);
    pulse_ack();
    exp_req("tick_ack", 1'b0, 3'd0);
    exp_rd("tick_status", 2'd3, 32'h001);
    exp_rd("tick_pend_clr", 2'd1, 32'h0);
    exp_gie("tick_gie_low", 1'b0);
    irq_in = 8'h00;
    pulse_eoi();
    cyc(1);
    exp_gie("tick_gie_back", 1'b1);
    exp_rd("tick_status_idle", 2'd3, 32'h000);

    // preemption by higher priority line 2 over line 5
    wr(2'd0, 32'hFF);
    irq_in = 8'h20;
    cyc(2);
    exp_req("pre_l5", 1'b1, 3'd5);
    irq_in = 8'h24;
    cyc(1);
    exp_req("pre_l5_hold", 1'b1, 3'd5);
    cyc(1);
    exp_req("pre_l2", 1'b1, 3'd2);
    pulse_ack();
    exp_req("pre_ack", 1'b0, 3'd0);
    exp_rd("pre_status", 2'd3, 32'h201);
    exp_rd("pre_pending", 2'd1, 32'h20);
    pulse_eoi();
    cyc(1);
    exp_req("pre_reassert", 1'b1, 3'd5);
    pulse_ack();
    pulse_eoi();
    irq_in = 8'h00;
    cyc(2);

    // masked line still latches pending
    wr(2'd0, 32'h00);
    irq_in = 8'h08;
    cyc(2);
    exp_rd("mask_pending", 2'd1, 32'h08);
    exp_req("mask_noreq", 1'b0, 3'd0);
    wr(2'd0, 32'h08);
    cyc(1);
    exp_req("mask_enable", 1'b1, 3'd3);
    pulse_ack();
    pulse_eoi();
    irq_in = 8'h00;
    cyc(2);

    // set beats coincident W1C
    wr(2'd0, 32'h00);
    irq_in = 8'h02;
    wr(2'd1, 32'h02);
    exp_rd("race_set_wins", 2'd1, 32'h02);
    wr(2'd1, 32'h02);
    cyc(1);
    exp_rd("w1c_held_line", 2'd1, 32'h00);
    irq_in = 8'h00;
    cyc(1);

    // reset in the middle of a service
    wr(2'd0, 32'hFF);
    irq_in = 8'h40;
    cyc(2);
    exp_req("rst_l6", 1'b1, 3'd6);
    bus.int_ack = 1'b1;
    irq_in = 8'h50;
    cyc(1);
    bus.int_ack = 1'b0;
    exp_rd("rst_status_svc", 2'd3, 32'h601);
    exp_rd("rst_pend_svc", 2'd1, 32'h10);
    clr = 1'b0;
    cyc(1);
    clr = 1'b1;
    exp_rd("rst_status", 2'd3, 32'h0);
    exp_req("rst_req", 1'b0, 3'd0);
    exp_rd("rst_pending", 2'd1, 32'h0);
    exp_rd("rst_mask", 2'd0, 32'h0);
    exp_gie("rst_gie", 1'b0);
    wr(2'd0, 32'hFF);
    wr(2'd2, 32'h1);
    cyc(2);
    exp_req("rst_no_retrigger", 1'b0, 3'd0);
    irq_in = 8'h80;
    cyc(2);
    exp_req("rst_fresh_req", 1'b1, 3'd7);
    pulse_eoi();
    exp_req("eoi_in_req_ignored", 1'b1, 3'd7);
    wr(2'd2, 32'h0);
    cyc(1);
    exp_req("ie_off_drop", 1'b0, 3'd0);
    exp_rd("ie_off_pending", 2'd1, 32'h80);

    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
